// File: rtl/stream_framer.sv
// stream_framer: buffers a valid-only word stream and emits header+payload frames on valid/ready.
// Define STREAM_FRAMER_SEQ_CHECK_EN to build the +1 input sequence checker driving seq_err_out.
module stream_framer #(
  parameter int          FIFO_DEPTH = 512,
  parameter int          FRAME_LEN  = 256,
  parameter logic [15:0] HDR_TAG    = 16'hA5A5
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [31:0]                 data_in,
  input  logic                        valid_in,
  output logic [31:0]                 data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        sof_out,
  output logic                        eof_out,
  output logic                        overflow_out,
  output logic [$clog2(FIFO_DEPTH):0] level_out,
  output logic                        seq_err_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  state_t        state, state_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [15:0]   frame_seq, seq_d;
  logic [31:0]   data_d;
  logic          valid_d, sof_d, eof_d, full, push, pop;
  // full is taken before any same-cycle pop, so a pop never rescues an incoming word
  assign full   = level_out == (AW+1)'(FIFO_DEPTH);
  assign push   = valid_in && !full;
  assign rd_nxt = rd_ptr + AW'(1);
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= data_in;
  // data_out is prefetched from the FIFO head on each handshake, keeping every output registered
  always_comb begin
    state_d = state;
    valid_d = valid_out;
    sof_d   = sof_out;
    eof_d   = eof_out;
    data_d  = data_out;
    cnt_d   = cnt;
    seq_d   = frame_seq;
    pop     = 1'b0;
    case (state)
      IDLE: if (level_out >= (AW+1)'(FRAME_LEN)) begin
        state_d = HDR;
        valid_d = 1'b1;
        sof_d   = 1'b1;
        data_d  = {HDR_TAG, frame_seq};
      end
      HDR: if (ready_in) begin
        state_d = PAY;
        sof_d   = 1'b0;
        data_d  = mem[rd_ptr];
        cnt_d   = CW'(1);
        eof_d   = FRAME_LEN == 1;
      end
      PAY: if (ready_in) begin
        pop = 1'b1;
        if (eof_out) begin
          state_d = IDLE;
          valid_d = 1'b0;
          eof_d   = 1'b0;
          seq_d   = frame_seq + 16'd1;
        end else begin
          data_d = mem[rd_nxt];
          cnt_d  = cnt + CW'(1);
          eof_d  = cnt == CW'(FRAME_LEN - 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      state        <= IDLE;
      data_out     <= '0;
      valid_out    <= 1'b0;
      sof_out      <= 1'b0;
      eof_out      <= 1'b0;
      cnt          <= '0;
      frame_seq    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_out    <= '0;
      overflow_out <= 1'b0;
    end else begin
      state        <= state_d;
      data_out     <= data_d;
      valid_out    <= valid_d;
      sof_out      <= sof_d;
      eof_out      <= eof_d;
      cnt          <= cnt_d;
      frame_seq    <= seq_d;
      wr_ptr       <= wr_ptr + AW'(push);
      rd_ptr       <= rd_ptr + AW'(pop);
      level_out    <= level_out + (AW+1)'(push) - (AW+1)'(pop);
      overflow_out <= overflow_out | (valid_in && full);
    end
`ifdef STREAM_FRAMER_SEQ_CHECK_EN
  logic [31:0] last_word;
  logic        have_last;
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      last_word   <= '0;
      have_last   <= 1'b0;
      seq_err_out <= 1'b0;
    end else if (push) begin
      last_word   <= data_in;
      have_last   <= 1'b1;
      seq_err_out <= seq_err_out | (have_last && data_in != last_word + 32'd1);
    end
`else
  assign seq_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: scoreboard bench for stream_framer; frames are predicted as input words are accepted.
module tb_stream_framer;
  localparam int DEPTH = 512;
  localparam int FLEN  = 256;
  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eof;
  } beat_t;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out, sof_out, eof_out, overflow_out, seq_err_out;
  logic [$clog2(DEPTH):0] level_out;
  beat_t       exp_q[$];
  logic [31:0] pend_q[$];
  logic [15:0] tb_seq = '0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic        prev_hold = 1'b0;
  logic        prev_stall = 1'b0;
  beat_t       prev_b = '0;

  stream_framer #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN), .HDR_TAG(16'hA5A5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .sof_out(sof_out),
    .eof_out(eof_out), .overflow_out(overflow_out), .level_out(level_out), .seq_err_out(seq_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic beat_t mk(input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d;
    b.sof = s;
    b.eof = e;
    return b;
  endfunction

  // scoreboard: pop on every handshake; also check hold-while-stalled and no mid-frame valid drop
  always @(negedge clk_in) begin
    beat_t cur, e;
    cur = mk(data_out, sof_out, eof_out);
    if (!rst_n_in) begin
      prev_hold = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_hold) begin
        chk_cnt++;
        if (valid_out !== 1'b1) $display("FAIL valid_drop: valid_out=%b expected 1", valid_out);
        else pass_cnt++;
      end
      if (prev_stall) begin
        chk_cnt++;
        if (cur !== prev_b) $display("FAIL stall_hold: got %h expected %h", cur, prev_b);
        else pass_cnt++;
      end
      if (valid_out === 1'b1 && ready_in) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL beat: got unexpected %h expected none", cur);
        else begin
          e = exp_q.pop_front();
          if (cur !== e) $display("FAIL beat: got data=%h sof=%b eof=%b expected data=%h sof=%b eof=%b",
                                  cur.d, cur.sof, cur.eof, e.d, e.sof, e.eof);
          else pass_cnt++;
        end
      end
      prev_hold  = valid_out === 1'b1 && !(ready_in && eof_out);
      prev_stall = valid_out === 1'b1 && !ready_in;
      prev_b     = cur;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input bit keep);
    data_in = d;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    if (keep) begin
      pend_q.push_back(d);
      if (pend_q.size() == FLEN) begin
        exp_q.push_back(mk({16'hA5A5, tb_seq}, 1'b1, 1'b0));
        for (int i = 0; i < FLEN; i++) exp_q.push_back(mk(pend_q[i], 1'b0, i == FLEN - 1));
        pend_q.delete();
        tb_seq++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: %0d beats left, expected 0", name, exp_q.size());
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if (level_out !== 0) $display("FAIL %s_level: got %0d expected 0", name, level_out);
    else pass_cnt++;
  endtask

  task automatic check_zero(input string name);
    chk_cnt++;
    if ({data_out, valid_out, sof_out, eof_out, overflow_out, seq_err_out} !== '0 || level_out !== 0)
      $display("FAIL %s: data=%h v=%b sof=%b eof=%b ovf=%b serr=%b level=%0d expected all 0",
               name, data_out, valid_out, sof_out, eof_out, overflow_out, seq_err_out, level_out);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    tick();
    rst_n_in = 1'b0;
    repeat (2) tick();
    rst_n_in = 1'b1;
    check_zero("reset");
  endtask

  task automatic test_first_frame();
    ready_in = 1'b1;
    for (int i = 0; i < FLEN; i++) push_word(i, 1'b1);
    chk_cnt++;
    if (overflow_out !== 1'b0) $display("FAIL first_overflow: got %b expected 0", overflow_out);
    else pass_cnt++;
    chk_cnt++;
    if (level_out !== FLEN) $display("FAIL first_level: got %0d expected %0d", level_out, FLEN);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fork
      for (int i = FLEN; i < 2 * FLEN; i++) push_word(i, 1'b1);
      begin
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 2000) begin
          @(negedge clk_in);
          n++;
          got = valid_out && ready_in && eof_out;
        end
        chk_cnt++;
        if (!got) $display("FAIL b2b_eof: no eof within %0d cycles, expected one", n);
        else pass_cnt++;
        n = 0;
        do begin
          @(negedge clk_in);
          n++;
        end while (!(valid_out && sof_out) && n < 10);
        chk_cnt++;
        if (n != 2) $display("FAIL b2b_gap: next sof after %0d cycles, expected 2", n);
        else pass_cnt++;
      end
    join
    wait_drain("b2b");
  endtask

  task automatic test_stall();
    fork
      for (int i = 2 * FLEN; i < 3 * FLEN; i++) push_word(i, 1'b1);
      repeat (700) begin
        tick();
        ready_in = 1'($urandom_range(0, 1));
      end
    join
    ready_in = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_overflow();
    ready_in = 1'b0;
    for (int i = 0; i < 600; i++) begin
      push_word(i, i < DEPTH);
      if (i == DEPTH - 1) begin
        chk_cnt++;
        if (level_out !== DEPTH || overflow_out !== 1'b0)
          $display("FAIL ovf_full: level=%0d ovf=%b expected level=%0d ovf=0", level_out, overflow_out, DEPTH);
        else pass_cnt++;
      end
      if (i == DEPTH) begin
        chk_cnt++;
        if (overflow_out !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow_out);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (level_out !== DEPTH) $display("FAIL ovf_level: got %0d expected %0d", level_out, DEPTH);
    else pass_cnt++;
    ready_in = 1'b1;
    wait_drain("ovf");
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b1;
    for (int i = 0; i < FLEN; i++) push_word(32'h1000 + i, 1'b1);
    repeat (10) tick();
    exp_q.delete();
    pend_q.delete();
    tb_seq = '0;
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    check_zero("mid_reset");
    for (int i = 0; i < FLEN; i++) push_word(32'h2000 + i, 1'b1);
    wait_drain("after_reset");
  endtask

  task automatic test_seq_check();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    ready_in = 1'b0;
`ifdef STREAM_FRAMER_SEQ_CHECK_EN
    push_word(32'hFFFF_FFFE, 1'b0);
    push_word(32'hFFFF_FFFF, 1'b0);
    push_word(32'h0, 1'b0);
    push_word(32'h1, 1'b0);
    chk_cnt++;
    if (seq_err_out !== 1'b0) $display("FAIL seq_wrap: got %b expected 0", seq_err_out);
    else pass_cnt++;
    push_word(32'h5, 1'b0);
    chk_cnt++;
    if (seq_err_out !== 1'b1) $display("FAIL seq_err: got %b expected 1", seq_err_out);
    else pass_cnt++;
    push_word(32'h6, 1'b0);
    repeat (3) tick();
    chk_cnt++;
    if (seq_err_out !== 1'b1) $display("FAIL seq_sticky: got %b expected 1", seq_err_out);
    else pass_cnt++;
`else
    push_word(32'h1, 1'b0);
    push_word(32'h5, 1'b0);
    chk_cnt++;
    if (seq_err_out !== 1'b0) $display("FAIL seq_tied: got %b expected 0", seq_err_out);
    else pass_cnt++;
`endif
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    check_zero("seq_reset");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_seq_check();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
